// File: rtl/kfps2kb_pkg.sv
// Shared constants and types for the keyboard keycode buffer.
package kfps2kb_pkg;

  localparam logic [7:0] KEYCODE_OVERRUN = 8'hFF;
  localparam logic [7:0] KEYCODE_BAT_OK  = 8'hAA;

  typedef enum logic {
    StIdle,
    StClear
  } capture_state_e;

endpackage

// File: rtl/kfps2kb_fifo.sv
// Keycode FIFO storage and pointers with flush and tail-overwrite support.
module kfps2kb_fifo
  import kfps2kb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic                     overwrite_tail_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop, do_overwrite;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // A pop frees a slot in the same cycle, so a push into a full FIFO may proceed alongside it.
  assign do_pop       = pop_i && !empty_o;
  assign do_push      = push_i && (!full_o || do_pop);
  assign do_overwrite = overwrite_tail_i && full_o && !do_push;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + AW'(1);
      if (do_pop)  rptr_d = rptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush_i) begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
      end else if (do_overwrite) begin
        mem_q[wptr_q - AW'(1)] <= KEYCODE_OVERRUN;
      end
    end
  end

endmodule

// File: rtl/kfps2kb_keycode_buffer.sv
// Buffers XT keycodes from the keyboard controller for the PPI side, with upstream handshake,
// pop/flush edge detection and sticky overrun reporting.
module kfps2kb_keycode_buffer
  import kfps2kb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   kb_irq,
  input  logic [7:0]             kb_keycode,
  output logic                   kb_clear_keycode,
  output logic                   kb_reset_keybord,
  output logic                   irq,
  output logic [7:0]             keycode,
  input  logic                   clear_keycode,
  input  logic                   reset_keybord,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow
);

  capture_state_e state_q, state_d;
  logic           clear_prev_q;
  logic           reset_kb_prev_q;
  logic           kb_reset_pulse_q;
  logic           overflow_q, overflow_d;
  logic           pop_edge, flush_edge, capture;
  logic           fifo_empty, fifo_full;
  logic [7:0]     fifo_head;

  assign pop_edge   = clear_keycode && !clear_prev_q;
  assign flush_edge = reset_keybord && !reset_kb_prev_q;
  // Flush wins: a keycode arriving in the flush cycle is dropped without acknowledge.
  assign capture    = (state_q == StIdle) && kb_irq && !flush_edge;

  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    if (flush_edge) begin
      state_d    = StIdle;
      overflow_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle:  if (kb_irq) state_d = StClear;
        StClear: state_d = StIdle;
        default: state_d = StIdle;
      endcase
      if (capture && fifo_full && !(pop_edge && !fifo_empty)) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= StIdle;
      clear_prev_q     <= 1'b0;
      reset_kb_prev_q  <= 1'b0;
      kb_reset_pulse_q <= 1'b0;
      overflow_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      clear_prev_q     <= clear_keycode;
      reset_kb_prev_q  <= reset_keybord;
      kb_reset_pulse_q <= flush_edge;
      overflow_q       <= overflow_d;
    end
  end

  kfps2kb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock           (clock),
    .reset           (reset),
    .push_i          (capture),
    .pop_i           (pop_edge),
    .flush_i         (flush_edge),
    .overwrite_tail_i(capture),
    .wdata_i         (kb_keycode),
    .head_o          (fifo_head),
    .count_o         (fifo_count),
    .empty_o         (fifo_empty),
    .full_o          (fifo_full)
  );

  assign kb_clear_keycode = (state_q == StClear);
  assign kb_reset_keybord = kb_reset_pulse_q;
  assign irq              = !fifo_empty && !clear_keycode;
  assign keycode          = fifo_empty ? 8'h00 : fifo_head;
  assign overflow         = overflow_q;

endmodule

// File: tb/tb_kfps2kb_keycode_buffer.sv
// Scoreboard bench for kfps2kb_keycode_buffer: expected keycodes are queued on push
// and compared against the FIFO head as the PPI side pops them.
module tb_kfps2kb_keycode_buffer;
  import kfps2kb_pkg::*;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clock = 1'b0;
  logic          reset;
  logic          kb_irq;
  logic [7:0]    kb_keycode;
  logic          kb_clear_keycode;
  logic          kb_reset_keybord;
  logic          irq;
  logic [7:0]    keycode;
  logic          clear_keycode;
  logic          reset_keybord;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [7:0]  exp_q [$];
  logic        exp_ovf;

  kfps2kb_keycode_buffer #(
    .DEPTH(DEPTH)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .kb_irq          (kb_irq),
    .kb_keycode      (kb_keycode),
    .kb_clear_keycode(kb_clear_keycode),
    .kb_reset_keybord(kb_reset_keybord),
    .irq             (irq),
    .keycode         (keycode),
    .clear_keycode   (clear_keycode),
    .reset_keybord   (reset_keybord),
    .fifo_count      (fifo_count),
    .overflow        (overflow)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_count"}, 16'(fifo_count), 16'(exp_q.size()));
    check_eq({tag, "_ovf"}, 16'(overflow), 16'(exp_ovf));
    check_eq({tag, "_key"}, 16'(keycode), (exp_q.size() != 0) ? 16'(exp_q[0]) : 16'h0000);
    check_eq({tag, "_irq"}, 16'(irq), 16'((exp_q.size() != 0) && !clear_keycode));
  endtask

  task automatic model_push(input logic [7:0] c, input bit popping);
    if (exp_q.size() == DEPTH && !popping) begin
      exp_q[exp_q.size()-1] = KEYCODE_OVERRUN;
      exp_ovf = 1'b1;
    end else begin
      exp_q.push_back(c);
    end
  endtask

  // Full upstream handshake: raise kb_irq, expect the ack, then release.
  task automatic send_code(input logic [7:0] c);
    @(negedge clock);
    kb_irq     = 1'b1;
    kb_keycode = c;
    @(negedge clock);
    check_eq("ack_hi", 16'(kb_clear_keycode), 16'h1);
    kb_irq = 1'b0;
    model_push(c, 1'b0);
    @(negedge clock);
    check_eq("ack_lo", 16'(kb_clear_keycode), 16'h0);
  endtask

  // Compare head with the scoreboard, then pop it with a clear_keycode pulse of `hold` cycles.
  task automatic pop_code(input int hold);
    @(negedge clock);
    check_state("pre_pop");
    clear_keycode = 1'b1;
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    repeat (hold) begin
      @(negedge clock);
      check_eq("pop_irq_masked", 16'(irq), 16'h0);
    end
    check_eq("pop_count", 16'(fifo_count), 16'(exp_q.size()));
    clear_keycode = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    kb_irq        = 1'b0;
    kb_keycode    = 8'h00;
    clear_keycode = 1'b0;
    reset_keybord = 1'b0;
    exp_ovf       = 1'b0;
    repeat (3) @(negedge clock);
    check_state("reset");
    check_eq("reset_ack", 16'(kb_clear_keycode), 16'h0);
    check_eq("reset_kbrst", 16'(kb_reset_keybord), 16'h0);
    reset = 1'b0;

    // Single keycode: visible one cycle after kb_irq is sampled.
    @(negedge clock);
    kb_irq     = 1'b1;
    kb_keycode = 8'h1E;
    @(negedge clock);
    check_eq("lat_ack", 16'(kb_clear_keycode), 16'h1);
    check_eq("lat_irq", 16'(irq), 16'h1);
    check_eq("lat_key", 16'(keycode), 16'h1E);
    check_eq("lat_count", 16'(fifo_count), 16'h1);
    kb_irq = 1'b0;
    model_push(8'h1E, 1'b0);
    @(negedge clock);
    check_eq("lat_ack_lo", 16'(kb_clear_keycode), 16'h0);
    pop_code(1);

    // Pop while empty is ignored.
    pop_code(1);

    // Ordering and hold-high pops once.
    send_code(8'h10);
    send_code(8'h11);
    send_code(8'h12);
    pop_code(5);
    pop_code(1);
    pop_code(1);
    @(negedge clock);
    check_state("after_three");

    // Overrun: 17 codes into a 16-deep FIFO.
    for (int i = 1; i <= 17; i++) send_code(8'(i));
    @(negedge clock);
    check_state("overrun");
    for (int i = 0; i < 16; i++) pop_code(1);
    @(negedge clock);
    check_state("overrun_drained");

    // Flush coincident with an upstream keycode.
    send_code(8'h21);
    send_code(8'h22);
    send_code(8'h23);
    @(negedge clock);
    reset_keybord = 1'b1;
    kb_irq        = 1'b1;
    kb_keycode    = 8'h55;
    exp_q.delete();
    exp_ovf = 1'b0;
    @(negedge clock);
    kb_irq = 1'b0;
    check_state("flush");
    check_eq("flush_pulse", 16'(kb_reset_keybord), 16'h1);
    check_eq("flush_no_ack", 16'(kb_clear_keycode), 16'h0);
    @(negedge clock);
    check_eq("flush_pulse_end", 16'(kb_reset_keybord), 16'h0);
    reset_keybord = 1'b0;
    send_code(KEYCODE_BAT_OK);
    @(negedge clock);
    check_state("bat_ok");
    pop_code(1);

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 16; i++) send_code(8'h40 + 8'(i));
    @(negedge clock);
    kb_irq        = 1'b1;
    kb_keycode    = 8'h7A;
    clear_keycode = 1'b1;
    void'(exp_q.pop_front());
    model_push(8'h7A, 1'b1);
    @(negedge clock);
    kb_irq = 1'b0;
    check_eq("full_pp_ack", 16'(kb_clear_keycode), 16'h1);
    check_eq("full_pp_count", 16'(fifo_count), 16'(DEPTH));
    check_eq("full_pp_ovf", 16'(overflow), 16'h0);
    clear_keycode = 1'b0;
    for (int i = 0; i < 16; i++) pop_code(1);
    @(negedge clock);
    check_state("full_pp_drained");

    // Reset while the acknowledge is being driven.
    @(negedge clock);
    kb_irq     = 1'b1;
    kb_keycode = 8'h33;
    @(negedge clock);
    check_eq("rst_mid_ack", 16'(kb_clear_keycode), 16'h1);
    reset  = 1'b1;
    kb_irq = 1'b0;
    @(negedge clock);
    exp_q.delete();
    exp_ovf = 1'b0;
    check_state("rst_mid");
    check_eq("rst_mid_ack_lo", 16'(kb_clear_keycode), 16'h0);
    check_eq("rst_mid_kbrst", 16'(kb_reset_keybord), 16'h0);
    reset = 1'b0;
    @(negedge clock);
    check_eq("rst_mid_no_ack", 16'(kb_clear_keycode), 16'h0);
    check_state("rst_mid_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kfps2kb_keycode_buffer.md
KFPS2KB_KEYCODE_BUFFER -- requirements
Module: kfps2kb_keycode_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 2..256).
REQ-002 SHALL have clock  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have kb_irq  input  1  upstream keyboard controller has a keycode pending.
REQ-005 SHALL have kb_keycode  input  8  upstream XT keycode, valid while kb_irq=1.
REQ-006 SHALL have kb_clear_keycode  output  1  one-cycle acknowledge to upstream.
REQ-007 SHALL have kb_reset_keybord  output  1  one-cycle keyboard-reset request to upstream.
REQ-008 SHALL have irq  output  1  keycode available to the PPI/interrupt side.
REQ-009 SHALL have keycode  output  8  FIFO head entry.
REQ-010 SHALL have clear_keycode  input  1  level from PPI port B bit 7; rising edge pops.
REQ-011 SHALL have reset_keybord  input  1  level from PPI side; rising edge flushes and resets.
REQ-012 SHALL have fifo_count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 SHALL have overflow  output  1  sticky overrun flag.

Function
REQ-014 Capture FSM SHALL have states IDLE and CLEAR.
REQ-015 In IDLE with kb_irq=1, SHALL push kb_keycode and enter CLEAR.
REQ-016 In CLEAR, SHALL drive kb_clear_keycode=1, ignore kb_irq, and return to IDLE next cycle.
REQ-017 Push latency SHALL be 1: kb_irq seen in cycle N makes irq=1, keycode valid in N+1 (FIFO previously empty).
REQ-018 irq SHALL equal (fifo_count!=0) AND NOT clear_keycode.
REQ-019 keycode SHALL show the head entry when not empty, and 8'h00 when empty.
REQ-020 A rising edge of clear_keycode (registered previous level) SHALL pop one entry; holding it high pops once.
REQ-021 A pop while empty SHALL be ignored.
REQ-022 Push and pop in the same cycle SHALL both occur; fifo_count unchanged.
REQ-023 Push while full and no pop: incoming byte SHALL be discarded, most recently written entry SHALL be overwritten with 8'hFF, overflow SHALL be set, fifo_count SHALL stay DEPTH.
REQ-024 Push while full with simultaneous pop SHALL be a normal push; overflow unchanged.
REQ-025 Pointers SHALL wrap modulo DEPTH.
REQ-026 A rising edge of reset_keybord SHALL, in that cycle, empty the FIFO, clear overflow, force the FSM to IDLE, and pulse kb_reset_keybord=1 for exactly one cycle in the next cycle.
REQ-027 Flush SHALL take priority over push and pop in the same cycle; the concurrent upstream keycode SHALL be discarded.
REQ-028 The upstream 8'hAA produced after kb_reset_keybord SHALL be captured as a normal push.
REQ-029 overflow SHALL clear only on reset or flush.

Reset
REQ-030 On reset, outputs SHALL be: irq=0, keycode=8'h00, kb_clear_keycode=0, kb_reset_keybord=0, fifo_count=0, overflow=0.
REQ-031 On reset, FSM SHALL be IDLE and edge-detect registers SHALL be 0.
REQ-032 Reset mid-handshake SHALL abort CLEAR with no acknowledge pulse on the following cycle.

Structure
REQ-033 Package kfps2kb_pkg SHALL hold KEYCODE_OVERRUN=8'hFF, KEYCODE_BAT_OK=8'hAA, and the capture-state enum.
REQ-034 Storage and pointers SHALL be one sub-module, kfps2kb_fifo (push, pop, flush, overwrite_tail, head, count).
REQ-035 FSM, edge detection and overflow policy SHALL stay in the top module.

Verification
REQ-036 kb_irq=1, kb_keycode=8'h1E; release kb_irq after the kb_clear_keycode pulse -> one-cycle kb_clear_keycode, next cycle irq=1, keycode=8'h1E, fifo_count=1.
REQ-037 Push 8'h10, 8'h11, 8'h12, then three clear_keycode rising edges -> keycode sequence 8'h10, 8'h11, 8'h12; irq=0 after the third pop; clear_keycode held 5 cycles -> only one pop.
REQ-038 DEPTH=16, push 17 codes 8'h01..8'h11 with no pops -> fifo_count=16, entry 16 reads 8'hFF, overflow=1; 8'h11 is never output.
REQ-039 FIFO full, push and clear_keycode edge in the same cycle -> fifo_count stays 16, overflow=0, new code at tail.
REQ-040 3 entries queued, then reset_keybord rising edge coincident with kb_irq=1 -> fifo_count=0, one-cycle kb_reset_keybord, coincident code dropped; upstream 8'hAA then yields irq=1, keycode=8'hAA.
REQ-041 Assert reset during CLEAR -> all outputs at reset values next cycle; no kb_clear_keycode pulse follows.
